ecc_serial_port: RTL
====================

// Module: ecc_serial_port
// PURPOSE
//  Bit-serial I/O front end for the ECC scalar-multiply core, generalised in operand count and length.
//  Deserialises a start pulse, a 2-bit mode and NUM_IN MSB-first operand streams into zero-extended parallel registers.
//  Hands the operands to the core with a valid/ready handshake.
//  Serialises the core's NUM_OUT results back out MSB-first behind a one-cycle valid marker.
// PARAMETERS
//  BITS     256  maximum operand width; register width of every operand/result
//  NUM_IN   6    serial input channels (a, b, prime, Px, Py, m)
//  NUM_OUT  2    serial output channels (x, y)
// PORTS
//  clk          in   1               single clock, all logic rising-edge
//  rst          in   1               synchronous, active-high reset
//  i_valid      in   1               start pulse; honoured only in S_IDLE
//  i_mode       in   1               mode[1] in cycle t+1, mode[0] in cycle t+2 after i_valid
//  i_data       in   NUM_IN          one bit per channel per cycle, MSB first
//  o_op_valid   out  1               parallel operands stable and valid
//  i_op_ready   in   1               core accepts operands
//  o_ops        out  NUM_IN*BITS     channel k at [k*BITS +: BITS], zero-extended
//  o_mode       out  2               latched mode
//  i_res_valid  in   1               core result available
//  o_res_ready  out  1               port can accept a result (serializer idle)
//  i_res        in   NUM_OUT*BITS    channel k at [k*BITS +: BITS]
//  o_valid      out  1               one-cycle marker; first result bit follows next cycle
//  o_data       out  NUM_OUT         serial result bits, MSB first
//  o_busy       out  1               either FSM not idle
// BEHAVIOUR
//  Length: LEN = BITS >> (3 - mode). mode 00/01/10/11 -> 32/64/128/256 at BITS=256.
//  Reset: o_op_valid=0, o_valid=0, o_data=0, o_ops=0, o_mode=0, o_busy=0, o_res_ready=1. Both FSMs to idle, counters 0.
//  Input FSM S_IDLE -> S_M1 -> S_M0 -> S_SHIFT -> S_HOLD -> S_IDLE:
//   - i_valid in S_IDLE (cycle t): clear all operand regs; go to S_M1.
//   - t+1: sample i_mode into mode[1]. t+2: sample i_mode into mode[0], then load counter with LEN-1.
//   - t+3 .. t+2+LEN: reg_k <= {reg_k[BITS-2:0], i_data[k]}. Upper BITS-LEN bits stay 0.
//   - t+3+LEN: o_op_valid=1 and held, with o_ops/o_mode stable, until the cycle i_op_ready=1. Then S_IDLE.
//   - o_op_valid drops the cycle after acceptance.
//   - i_valid outside S_IDLE is ignored, including the acceptance cycle.
//   - X on i_mode outside t+1/t+2 is never sampled.
//  Output FSM O_IDLE -> O_MARK -> O_SHIFT -> O_IDLE:
//   - o_res_ready=1 only in O_IDLE. i_res_valid && o_res_ready at cycle r captures i_res.
//   - r+1: o_valid=1, o_data=0.
//   - r+2 .. r+1+LEN: o_data[k] = res_k[LEN-1-j] for j=0..LEN-1.
//   - r+2+LEN: O_IDLE, o_data=0.
//   - LEN is taken from o_mode latched at capture.
//  Independence: both FSMs run concurrently; a new input load may overlap an ongoing serialisation.
//  Reset mid-operation aborts both FSMs at once. No partial result or operand handshake is completed afterwards.
//  Counters are sized $clog2(BITS). Terminal count is compared, never wrapped.
// STRUCTURE
//  Package ecc_io_pkg: mode encoding localparams, function ecc_len(mode,BITS), input/output state enums.
//  Sub-module ecc_piso (parametrised BITS, NUM_OUT): capture, marker and MSB-first shift-out with its own length counter.
//  The input side stays in this module.
// TESTING
//  1) mode 00, a=0x0000_0001 ... m=0x8000_0000 -> o_op_valid at t+35, low ops exact, bits [255:32]=0, o_mode=00.
//  2) mode 11, 256-bit all-ones on channel 0; i_op_ready held 0 for 5 cycles -> o_op_valid holds 5 cycles with o_ops stable, drops the cycle after ready.
//  3) mode 01 latched, i_res x=0xDEAD_BEEF_0123_4567 -> o_valid at r+1, 64 bits MSB-first r+2..r+65, o_res_ready=1 at r+66.
//  4) i_valid re-pulsed during S_SHIFT and in the acceptance cycle -> ignored; operands unchanged.
//  5) rst=1 mid-shift (input bit 40 of 128, output bit 10) -> next cycle all outputs at reset values; fresh 32-bit load then succeeds.
//  6) new 32-bit load started during a 256-bit serialisation -> both complete with correct data and timing.

Source files
------------

// File: rtl/ecc_io_pkg.sv
// Shared definitions for the ECC serial I/O front end.
// Contents:
//   MODE_*    2-bit operand length encodings (32/64/128/256 bits at BITS=256)
//   ecc_len   active operand length for a mode: BITS >> (3 - mode)
//   in_state_e / out_state_e   deserializer and serializer FSM states
package ecc_io_pkg;

    localparam logic [1:0] MODE_32  = 2'b00;
    localparam logic [1:0] MODE_64  = 2'b01;
    localparam logic [1:0] MODE_128 = 2'b10;
    localparam logic [1:0] MODE_256 = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_M1,
        S_M0,
        S_SHIFT,
        S_HOLD
    } in_state_e;

    typedef enum logic [1:0] {
        O_IDLE,
        O_MARK,
        O_SHIFT
    } out_state_e;

    // Each mode step doubles the length, topping out at the full register width.
    function automatic int ecc_len(input logic [1:0] mode, input int bits);
        int len;
        case (mode)
            MODE_32:  len = bits >> 3;
            MODE_64:  len = bits >> 2;
            MODE_128: len = bits >> 1;
            MODE_256: len = bits;
            default:  len = bits;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/ecc_serial_port_if.sv
// Parallel side of the ECC serial port: operand handoff to the scalar-multiply
// core and result return from it.
// Signals:
//   o_op_valid / i_op_ready   operand handshake (port -> core)
//   o_ops                     NUM_IN operands, channel k at [k*BITS +: BITS]
//   o_mode                    latched 2-bit length mode
//   i_res_valid / o_res_ready result handshake (core -> port)
//   i_res                     NUM_OUT results, channel k at [k*BITS +: BITS]
// Modports: master = serial port side, slave = core side.
interface ecc_serial_port_if #(
    parameter int BITS    = 256,
    parameter int NUM_IN  = 6,
    parameter int NUM_OUT = 2
);

    logic                    o_op_valid;
    logic                    i_op_ready;
    logic [NUM_IN*BITS-1:0]  o_ops;
    logic [1:0]              o_mode;
    logic                    i_res_valid;
    logic                    o_res_ready;
    logic [NUM_OUT*BITS-1:0] i_res;

    modport master (
        output o_op_valid, o_ops, o_mode, o_res_ready,
        input  i_op_ready, i_res_valid, i_res
    );

    modport slave (
        input  o_op_valid, o_ops, o_mode, o_res_ready,
        output i_op_ready, i_res_valid, i_res
    );

endinterface

// File: rtl/ecc_piso.sv
// Result serializer: captures NUM_OUT parallel results, emits a one-cycle
// marker, then shifts the low LEN bits of every result out MSB first.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   res_valid_i   result offered by the core
//   res_i         NUM_OUT results, channel k at [k*BITS +: BITS]
//   mode_i        length mode, sampled together with the result
//   res_ready_o   high only while idle
//   valid_o       marker cycle, first data bit follows
//   data_o        serial result bits, zero outside the shift window
//   busy_o        serializer not idle
module ecc_piso
    import ecc_io_pkg::*;
#(
    parameter int BITS    = 256,
    parameter int NUM_OUT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    res_valid_i,
    input  logic [NUM_OUT*BITS-1:0] res_i,
    input  logic [1:0]              mode_i,
    output logic                    res_ready_o,
    output logic                    valid_o,
    output logic [NUM_OUT-1:0]      data_o,
    output logic                    busy_o
);

    localparam int CNT_W = $clog2(BITS);

    out_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BITS-1:0]  res_q [NUM_OUT];
    logic [BITS-1:0]  res_d [NUM_OUT];

    // State, bit-index counter and captured results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= O_IDLE;
            cnt_q   <= '0;
            for (int k = 0; k < NUM_OUT; k++) begin
                res_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int k = 0; k < NUM_OUT; k++) begin
                res_q[k] <= res_d[k];
            end
        end
    end

    // The counter doubles as the bit index: it starts at LEN-1 so the MSB of
    // the active window goes first, and the shift ends when it reaches zero.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        res_ready_o = 1'b0;
        valid_o     = 1'b0;
        data_o      = '0;
        case (state_q)
            O_IDLE: begin
                res_ready_o = 1'b1;
                if (res_valid_i) begin
                    for (int k = 0; k < NUM_OUT; k++) begin
                        res_d[k] = res_i[k*BITS +: BITS];
                    end
                    cnt_d   = CNT_W'(ecc_len(mode_i, BITS) - 1);
                    state_d = O_MARK;
                end
            end
            O_MARK: begin
                valid_o = 1'b1;
                state_d = O_SHIFT;
            end
            O_SHIFT: begin
                for (int k = 0; k < NUM_OUT; k++) begin
                    data_o[k] = res_q[k][cnt_q];
                end
                if (cnt_q == '0) begin
                    state_d = O_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = O_IDLE;
        endcase
    end

    assign busy_o = (state_q != O_IDLE);

endmodule

// File: rtl/ecc_serial_port.sv
// Bit-serial front end of the ECC scalar-multiply core.
// A start pulse is followed by two mode bits (MSB first) and then LEN bits on
// each of NUM_IN operand channels; the zero-extended operands are handed to
// the core over a valid/ready handshake. Results coming back are serialized
// by ecc_piso. Both directions run independently.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   i_valid    start pulse, only honoured while the input side is idle
//   i_mode     mode[1] one cycle after i_valid, mode[0] two cycles after
//   i_data     one bit per operand channel per cycle, MSB first
//   o_valid    one-cycle result marker
//   o_data     serial result bits
//   o_busy     either direction active
//   bus        operand/result handshake towards the core (master side)
module ecc_serial_port
    import ecc_io_pkg::*;
#(
    parameter int BITS    = 256,
    parameter int NUM_IN  = 6,
    parameter int NUM_OUT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    input  logic               i_mode,
    input  logic [NUM_IN-1:0]  i_data,
    output logic               o_valid,
    output logic [NUM_OUT-1:0] o_data,
    output logic               o_busy,
    ecc_serial_port_if.master  bus
);

    localparam int CNT_W = $clog2(BITS);

    in_state_e        in_state_q, in_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [BITS-1:0]  ops_q [NUM_IN];
    logic [BITS-1:0]  ops_d [NUM_IN];
    logic             piso_busy;

    // Input-side state, shift counter, latched mode and operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_state_q <= S_IDLE;
            cnt_q      <= '0;
            mode_q     <= '0;
            for (int k = 0; k < NUM_IN; k++) begin
                ops_q[k] <= '0;
            end
        end else begin
            in_state_q <= in_state_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            for (int k = 0; k < NUM_IN; k++) begin
                ops_q[k] <= ops_d[k];
            end
        end
    end

    // Operands are cleared on start so that shifting LEN bits in from the
    // bottom leaves the upper BITS-LEN bits at zero. The length counter is
    // loaded from the freshly completed mode, i.e. the live i_mode bit joined
    // with the already latched mode[1]. i_mode is only looked at in S_M1/S_M0.
    always_comb begin
        in_state_d = in_state_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        ops_d      = ops_q;
        case (in_state_q)
            S_IDLE: begin
                if (i_valid) begin
                    for (int k = 0; k < NUM_IN; k++) begin
                        ops_d[k] = '0;
                    end
                    in_state_d = S_M1;
                end
            end
            S_M1: begin
                mode_d[1]  = i_mode;
                in_state_d = S_M0;
            end
            S_M0: begin
                mode_d[0]  = i_mode;
                cnt_d      = CNT_W'(ecc_len({mode_q[1], i_mode}, BITS) - 1);
                in_state_d = S_SHIFT;
            end
            S_SHIFT: begin
                for (int k = 0; k < NUM_IN; k++) begin
                    ops_d[k] = {ops_q[k][BITS-2:0], i_data[k]};
                end
                if (cnt_q == '0) begin
                    in_state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_HOLD: begin
                if (bus.i_op_ready) begin
                    in_state_d = S_IDLE;
                end
            end
            default: in_state_d = S_IDLE;
        endcase
    end

    for (genvar k = 0; k < NUM_IN; k++) begin : g_ops
        assign bus.o_ops[k*BITS +: BITS] = ops_q[k];
    end

    assign bus.o_op_valid = (in_state_q == S_HOLD);
    assign bus.o_mode     = mode_q;
    assign o_busy         = (in_state_q != S_IDLE) || piso_busy;

    ecc_piso #(
        .BITS    (BITS),
        .NUM_OUT (NUM_OUT)
    ) u_piso (
        .clk         (clk),
        .rst         (rst),
        .res_valid_i (bus.i_res_valid),
        .res_i       (bus.i_res),
        .mode_i      (mode_q),
        .res_ready_o (bus.o_res_ready),
        .valid_o     (o_valid),
        .data_o      (o_data),
        .busy_o      (piso_busy)
    );

endmodule
